// File: rtl/spi_tx_if.sv
// spi_tx_if: word handshake in and SPI pins out of spi_tx.
interface spi_tx_if #(
   parameter int P_DATA_WIDTH = 8
);
   logic                    valid;
   logic [P_DATA_WIDTH-1:0] data;
   logic                    ready;
   logic                    sclk;
   logic                    mosi;
   logic                    cs_n;
   logic                    done;
   modport master (output valid, data, input ready, sclk, mosi, cs_n, done);
   modport slave (input valid, data, output ready, sclk, mosi, cs_n, done);
endinterface

// File: rtl/spi_tx.sv
// spi_tx: SPI mode-0 master transmitter, one word per valid/ready handshake, MSB first.
module spi_tx #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_CLK_DIV    = 4,
   parameter int P_CS_GAP     = 2
) (
   input logic     clk_100,
   input logic     a_rst,
   input logic     s_rst,
   spi_tx_if.slave bus
);
   localparam int CMAX = P_CLK_DIV > P_CS_GAP ? P_CLK_DIV : P_CS_GAP;
   localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
   localparam int BW   = $clog2(P_DATA_WIDTH);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [P_DATA_WIDTH-1:0] sh_q, sh_d;
   logic                    sclk_q, sclk_d, done_q, done_d;
   logic                    tc, gtc, act;
   // one counter serves as sclk divider and as cs_n gap timer
   assign tc  = cnt_q == CW'(P_CLK_DIV - 1);
   assign gtc = cnt_q == CW'(P_CS_GAP - 1);
   assign act = state_q inside {SETUP, SHIFT, HOLD};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      sclk_d  = sclk_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.valid) begin
               sh_d    = bus.data;
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: if (tc) begin
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: if (tc) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
            if (sclk_q) begin
               if (bit_q == BW'(P_DATA_WIDTH - 1)) state_d = HOLD;
               else begin
                  sh_d  = {sh_q[P_DATA_WIDTH-2:0], 1'b0};
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         HOLD: if (tc) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = P_CS_GAP == 0 ? IDLE : GAP;
         end
         GAP: if (gtc) begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (s_rst) begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         sh_d    = '0;
         sclk_d  = 1'b0;
         done_d  = 1'b0;
      end
   end
   always_ff @(posedge clk_100 or posedge a_rst) begin
      if (a_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         done_q  <= done_d;
      end
   end
   assign bus.ready = state_q == IDLE;
   assign bus.cs_n  = !act;
   assign bus.sclk  = sclk_q;
   assign bus.mosi  = act && sh_q[P_DATA_WIDTH-1];
   assign bus.done  = done_q;
endmodule

// File: tb/tb_spi_tx.sv
// tb_spi_tx: phase-based reference model checked every cycle, plus per-frame literal checks
// on a default instance and a fast (div 1, gap 0) instance.
module tb_spi_tx;
   localparam int L0 = 72, G0 = 2, L1 = 18, G1 = 0;
   typedef struct {
      logic [7:0] bits;
      int         low;
      int         rises;
   } frame_t;
   logic clk = 1'b0;
   logic ar0 = 1'b0, ar1 = 1'b0, sr0 = 1'b0, sr1 = 1'b0;
   int   total = 0, bad = 0;
   bit   chk_en = 1'b0;
   always #5 clk = ~clk;
   spi_tx_if #(.P_DATA_WIDTH(8)) b0 ();
   spi_tx_if #(.P_DATA_WIDTH(8)) b1 ();
   spi_tx u0 (.clk_100(clk), .a_rst(ar0), .s_rst(sr0), .bus(b0));
   spi_tx #(.P_DATA_WIDTH(8), .P_CLK_DIV(1), .P_CS_GAP(0)) u1 (.clk_100(clk), .a_rst(ar1), .s_rst(sr1), .bus(b1));
   logic [1:0] m_cs, m_sclk, m_mosi, m_rdy, m_done;
   assign m_cs   = {b1.cs_n, b0.cs_n};
   assign m_sclk = {b1.sclk, b0.sclk};
   assign m_mosi = {b1.mosi, b0.mosi};
   assign m_rdy  = {b1.ready, b0.ready};
   assign m_done = {b1.done, b0.done};
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask
   // expected {ready,sclk,mosi,cs_n,done}, ph = clock edges since the handshake edge
   function automatic logic [4:0] model(input int ph, input logic [7:0] w, input int d, input int g);
      int   l = 18 * d;
      int   q;
      logic r, s, m, c, dn;
      r  = ph == 0 || ph == l + g + 1;
      dn = ph == l + 1;
      c  = !(ph >= 1 && ph <= l);
      s  = 1'b0;
      m  = 1'b0;
      if (!c) begin
         q = ph - 1 - d;
         if (q < 0) m = w[7];
         else if (q < 16 * d) begin
            s = ((q / d) % 2) == 1;
            m = w[7 - q / (2 * d)];
         end else m = w[0];
      end
      return {r, s, m, c, dn};
   endfunction
   int ph0 = 0, ph1 = 0;
   logic [7:0] w0 = '0, w1 = '0;
   always @(posedge clk or posedge ar0)
      if (ar0 || sr0) ph0 <= 0;
      else if (ph0 == 0 || ph0 == L0 + G0 + 1) begin
         ph0 <= b0.valid ? 1 : 0;
         if (b0.valid) w0 <= b0.data;
      end else ph0 <= ph0 + 1;
   always @(posedge clk or posedge ar1)
      if (ar1 || sr1) ph1 <= 0;
      else if (ph1 == 0 || ph1 == L1 + G1 + 1) begin
         ph1 <= b1.valid ? 1 : 0;
         if (b1.valid) w1 <= b1.data;
      end else ph1 <= ph1 + 1;
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("cycle_dut0", {b0.ready, b0.sclk, b0.mosi, b0.cs_n, b0.done}, model(ph0, w0, 4, G0));
         check("cycle_dut1", {b1.ready, b1.sclk, b1.mosi, b1.cs_n, b1.done}, model(ph1, w1, 1, G1));
      end
   end
   frame_t     fq[2][$];
   int         gq[2][$], lq[2][$];
   int         dn[2], per[2], low_r[2], high_r[2], rises[2], lat[2], lastr[2];
   int         cyc = 0;
   logic [7:0] rx[2];
   bit         trk[2];
   logic       pcs[2] = '{1'b1, 1'b1};
   logic       psc[2] = '{1'b0, 1'b0};
   initial forever begin
      frame_t f;
      @(negedge clk);
      if (chk_en) begin
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (!m_cs[k] && pcs[k]) begin
               gq[k].push_back(high_r[k]);
               high_r[k] = 0; low_r[k] = 0; rises[k] = 0; rx[k] = '0;
            end
            if (m_cs[k] && !pcs[k]) begin
               f.bits = rx[k]; f.low = low_r[k]; f.rises = rises[k];
               fq[k].push_back(f);
               low_r[k] = 0; high_r[k] = 0; trk[k] = 1'b1; lat[k] = 0;
            end
            if (m_cs[k]) high_r[k]++; else low_r[k]++;
            if (m_sclk[k] && !psc[k]) begin
               rx[k] = {rx[k][6:0], m_mosi[k]};
               rises[k]++;
               per[k] = cyc - lastr[k];
               lastr[k] = cyc;
            end
            if (trk[k]) begin
               if (m_rdy[k]) begin
                  lq[k].push_back(lat[k]);
                  trk[k] = 1'b0;
               end else lat[k]++;
            end
            if (m_done[k]) dn[k]++;
            pcs[k] = m_cs[k];
            psc[k] = m_sclk[k];
         end
      end
   end
   task automatic drive(input int k, input logic v, input logic [7:0] w);
      if (k == 0) begin b0.valid = v; b0.data = w; end
      else begin b1.valid = v; b1.data = w; end
   endtask
   task automatic send(input int k, input logic [7:0] w, input bit hold);
      int n = 0;
      drive(k, 1'b1, w);
      while (!m_rdy[k] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("send_timeout", n, 0);
      @(negedge clk);
      if (!hold) drive(k, 1'b0, w);
   endtask
   task automatic wait_frames(input int k, input int n, input int budget);
      int t = 0;
      while (fq[k].size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (t >= budget) check("frame_timeout", fq[k].size(), n);
      repeat (6) @(negedge clk);
   endtask
   task automatic clr(input int k);
      fq[k].delete(); gq[k].delete(); lq[k].delete(); dn[k] = 0;
   endtask
   function automatic logic [31:0] fbits(input int k, input int i);
      return fq[k].size() > i ? {24'd0, fq[k][i].bits} : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] flow(input int k, input int i);
      return fq[k].size() > i ? fq[k][i].low : -1;
   endfunction
   function automatic logic [31:0] frises(input int k, input int i);
      return fq[k].size() > i ? fq[k][i].rises : -1;
   endfunction
   function automatic logic [31:0] lastgap(input int k);
      return gq[k].size() >= 2 ? gq[k][gq[k].size()-1] : -1;
   endfunction
   initial begin
      int n;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      #1 ar0 = 1'b1; ar1 = 1'b1;
      #3 check("reset_dut0", {b0.ready, b0.sclk, b0.mosi, b0.cs_n, b0.done}, 5'b10010);
      check("reset_dut1", {b1.ready, b1.sclk, b1.mosi, b1.cs_n, b1.done}, 5'b10010);
      @(negedge clk);
      ar0 = 1'b0; ar1 = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      clr(0);
      send(0, 8'hA5, 1'b0);
      wait_frames(0, 1, 200);
      check("a5_bits", fbits(0, 0), 8'hA5);
      check("a5_cs_low", flow(0, 0), 72);
      check("a5_rises", frises(0, 0), 8);
      check("a5_period", per[0], 8);
      check("a5_done", dn[0], 1);
      check("a5_ready_lat", lq[0].size() > 0 ? lq[0][0] : -1, 2);
      clr(0);
      send(0, 8'h3C, 1'b1);
      send(0, 8'hC3, 1'b0);
      wait_frames(0, 2, 400);
      check("b2b_first", fbits(0, 0), 8'h3C);
      check("b2b_second", fbits(0, 1), 8'hC3);
      check("b2b_gap", lastgap(0), 3);
      check("b2b_done", dn[0], 2);
      clr(0);
      send(0, 8'h5A, 1'b0);
      drive(0, 1'b0, 8'hFF);
      repeat (20) @(negedge clk);
      send(0, 8'hFF, 1'b0);
      wait_frames(0, 2, 400);
      check("stab_bits", fbits(0, 0), 8'h5A);
      check("stab_next", fbits(0, 1), 8'hFF);
      check("stab_gap", lastgap(0), 3);
      clr(0);
      send(0, 8'h96, 1'b0);
      n = 0;
      while (rises[0] < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("abort_wait_timeout", n, 0);
      check("abort_pre_sclk", b0.sclk, 1);
      #2 ar0 = 1'b1;
      #1 check("abort_a_outs", {b0.ready, b0.sclk, b0.mosi, b0.cs_n, b0.done}, 5'b10010);
      @(negedge clk);
      ar0 = 1'b0;
      repeat (90) @(negedge clk);
      check("abort_a_done", dn[0], 0);
      send(0, 8'h69, 1'b0);
      repeat (30) @(negedge clk);
      sr0 = 1'b1;
      @(negedge clk);
      sr0 = 1'b0;
      check("abort_s_outs", {b0.ready, b0.sclk, b0.mosi, b0.cs_n, b0.done}, 5'b10010);
      repeat (90) @(negedge clk);
      check("abort_s_done", dn[0], 0);
      clr(0);
      send(0, 8'hFF, 1'b0);
      wait_frames(0, 1, 200);
      check("ff_bits", fbits(0, 0), 8'hFF);
      check("ff_rises", frises(0, 0), 8);
      check("ff_cs_low", flow(0, 0), 72);
      check("ff_done", dn[0], 1);
      clr(1);
      send(1, 8'h81, 1'b1);
      send(1, 8'h7E, 1'b0);
      wait_frames(1, 2, 200);
      check("fast_bits", fbits(1, 0), 8'h81);
      check("fast_bits2", fbits(1, 1), 8'h7E);
      check("fast_cs_low", flow(1, 0), 18);
      check("fast_rises", frises(1, 0), 8);
      check("fast_period", per[1], 2);
      check("fast_gap", lastgap(1), 1);
      check("fast_ready_lat", lq[1].size() > 0 ? lq[1][0] : -1, 0);
      check("fast_done", dn[1], 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
